// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port Mem arbiter: state encoding, port
// indices, the all-lanes select constant and a byte-lane mask helper.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  localparam logic PORT_IF = 1'b0;  // instruction fetch
  localparam logic PORT_LS = 1'b1;  // load/store

  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_RESP  = ST_RESP,
    S_CLEAR = ST_CLEAR
  } state_e;

  // Expand a 4-bit byte-lane select into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{sel[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way request picker.
// Build option: MEM_ARB_RR_EN selects round-robin on a tie (the port that
// was not granted last wins); without it port 0 always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  output logic       gnt,
  output logic       any
);

`ifndef MEM_ARB_RR_EN
  // The fixed-priority picker has no use for the round-robin history.
  logic unused_rr;
  assign unused_rr = rr_last;
`endif

  // Choose the winning port; gnt is only meaningful while any is high.
  always_comb begin
    any = |req;
`ifdef MEM_ARB_RR_EN
    if (req == 2'b11) begin
      gnt = rr_last ? PORT_IF : PORT_LS;
    end else begin
      gnt = req[1] ? PORT_LS : PORT_IF;
    end
`else
    gnt = req[0] ? PORT_IF : PORT_LS;
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single word-wide Mem: p0 = instruction fetch,
// p1 = load/store, plus a whole-memory clear request. One access is in
// flight at a time: IDLE/RESP arbitrate, ISSUE drives Mem, RESP returns
// the ack (and the read word), CLEAR pulses mem_clr.
// Build option: MEM_ARB_RR_EN enables round-robin tie breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 20,
  parameter int MEM_DATA_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p0_req,
  input  logic                     p0_we,
  input  logic [3:0]               p0_sel,
  input  logic [MEM_ADDR_BITS-1:0] p0_addr,
  input  logic [MEM_DATA_BITS-1:0] p0_wdata,
  output logic                     p0_ack,
  output logic [MEM_DATA_BITS-1:0] p0_rdata,
  input  logic                     p1_req,
  input  logic                     p1_we,
  input  logic [3:0]               p1_sel,
  input  logic [MEM_ADDR_BITS-1:0] p1_addr,
  input  logic [MEM_DATA_BITS-1:0] p1_wdata,
  output logic                     p1_ack,
  output logic [MEM_DATA_BITS-1:0] p1_rdata,
  input  logic                     clr_req,
  output logic                     clr_done,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [MEM_DATA_BITS-1:0] mem_data_in,
  output logic                     mem_str,
  output logic                     mem_ld,
  output logic [3:0]               mem_sel,
  output logic                     mem_clr,
  input  logic [MEM_DATA_BITS-1:0] mem_data_out
);

  logic [1:0] req;
  logic       pick_gnt;
  logic       pick_any;
  logic       rr_last;

  assign req = {p1_req, p0_req};

`ifdef MEM_ARB_RR_EN
  logic rr_last_q, rr_last_d;
  assign rr_last = rr_last_q;
`else
  assign rr_last = 1'b1;
`endif

  mem_arb_pick u_pick (
    .req     (req),
    .rr_last (rr_last),
    .gnt     (pick_gnt),
    .any     (pick_any)
  );

  // Request fields of whichever port the picker chose this cycle.
  logic                     win_we;
  logic [3:0]               win_sel;
  logic [MEM_ADDR_BITS-1:0] win_addr;
  logic [MEM_DATA_BITS-1:0] win_wdata;

  assign win_we    = (pick_gnt == PORT_LS) ? p1_we    : p0_we;
  assign win_sel   = (pick_gnt == PORT_LS) ? p1_sel   : p0_sel;
  assign win_addr  = (pick_gnt == PORT_LS) ? p1_addr  : p0_addr;
  assign win_wdata = (pick_gnt == PORT_LS) ? p1_wdata : p0_wdata;

  state_e                   state_q, state_d;
  logic                     gnt_q, gnt_d;
  logic                     we_q, we_d;
  // Set when the current RESP cycle is the completion of a clear, not a port access.
  logic                     clr_phase_q, clr_phase_d;
  logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_DATA_BITS-1:0] mem_data_in_q, mem_data_in_d;
  logic                     mem_str_q, mem_str_d;
  logic                     mem_ld_q, mem_ld_d;
  logic [3:0]               mem_sel_q, mem_sel_d;
  logic                     mem_clr_q, mem_clr_d;

  // Next state, grant latch and the registered Mem pin values for the next cycle.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    clr_phase_d   = clr_phase_q;
    mem_addr_d    = '0;
    mem_data_in_d = '0;
    mem_str_d     = 1'b0;
    mem_ld_d      = 1'b0;
    mem_sel_d     = '0;
    mem_clr_d     = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_last_d     = rr_last_q;
`endif
    case (state_q)
      S_IDLE, S_RESP: begin
        if (clr_req) begin
          state_d   = S_CLEAR;
          mem_clr_d = 1'b1;
        end else if (pick_any) begin
          state_d       = S_ISSUE;
          gnt_d         = pick_gnt;
          we_d          = win_we;
          mem_addr_d    = win_addr;
          mem_sel_d     = win_sel;
          mem_data_in_d = win_wdata;
          mem_str_d     = win_we;
          mem_ld_d      = ~win_we;
`ifdef MEM_ARB_RR_EN
          rr_last_d     = pick_gnt;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d     = S_RESP;
        clr_phase_d = 1'b0;
      end
      S_CLEAR: begin
        state_d     = S_RESP;
        clr_phase_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      gnt_q         <= PORT_IF;
      we_q          <= 1'b0;
      clr_phase_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_str_q     <= 1'b0;
      mem_ld_q      <= 1'b0;
      mem_sel_q     <= '0;
      mem_clr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      we_q          <= we_d;
      clr_phase_q   <= clr_phase_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_str_q     <= mem_str_d;
      mem_ld_q      <= mem_ld_d;
      mem_sel_q     <= mem_sel_d;
      mem_clr_q     <= mem_clr_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin history; starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= PORT_LS;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_str     = mem_str_q;
  assign mem_ld      = mem_ld_q;
  assign mem_sel     = mem_sel_q;
  assign mem_clr     = mem_clr_q;

  // Acks and read data exist only in RESP; Mem's registered word is valid then.
  logic resp_port;
  assign resp_port = (state_q == S_RESP) && !clr_phase_q;
  assign clr_done  = (state_q == S_RESP) && clr_phase_q;
  assign p0_ack    = resp_port && (gnt_q == PORT_IF);
  assign p1_ack    = resp_port && (gnt_q == PORT_LS);
  assign p0_rdata  = (p0_ack && !we_q) ? mem_data_out : '0;
  assign p1_rdata  = (p1_ack && !we_q) ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter driving a small behavioural Mem (16 words).
// Runs in either build; expectations for the tie scenario follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk, rst_n;
  logic          p0_req, p0_we, p1_req, p1_we, clr_req;
  logic [3:0]    p0_sel, p1_sel;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack, clr_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic          mem_str, mem_ld, mem_clr;
  logic [3:0]    mem_sel;

  int checks = 0;
  int errors = 0;

  // Behavioural Mem: byte-masked write, masked registered read, full clear.
  logic [DW-1:0] mem_words [16];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem_words[i] <= '0;
    end else begin
      if (mem_str)
        mem_words[mem_addr] <= (mem_words[mem_addr] & ~lane_mask(mem_sel)) |
                               (mem_data_in & lane_mask(mem_sel));
      if (mem_ld)
        mem_data_out <= mem_words[mem_addr] & lane_mask(mem_sel);
    end
  end

  mem_arbiter #(.MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_sel(p0_sel), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_sel(p1_sel), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .clr_req(clr_req), .clr_done(clr_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_str(mem_str),
    .mem_ld(mem_ld), .mem_sel(mem_sel), .mem_clr(mem_clr),
    .mem_data_out(mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic port, input logic we, input logic [3:0] sel,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == PORT_IF) begin
      p0_we = we; p0_sel = sel; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_sel = sel; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
    end
  endtask

  // One complete access: ISSUE pins one cycle later, ack two cycles later.
  task automatic access(input logic port, input logic we, input logic [3:0] sel,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rdata, input string tag);
    drive(port, we, sel, addr, wdata);
    tick();
    check({tag, ".issue_str"}, mem_str, we);
    check({tag, ".issue_ld"}, mem_ld, !we);
    check({tag, ".issue_addr"}, mem_addr, addr);
    check({tag, ".issue_sel"}, mem_sel, sel);
    check({tag, ".issue_din"}, mem_data_in, wdata);
    check({tag, ".issue_noack"}, port ? p1_ack : p0_ack, 1'b0);
    tick();
    check({tag, ".ack"}, port ? p1_ack : p0_ack, 1'b1);
    check({tag, ".other_ack"}, port ? p0_ack : p1_ack, 1'b0);
    check({tag, ".rdata"}, port ? p1_rdata : p0_rdata, exp_rdata);
    check({tag, ".resp_str"}, mem_str, 1'b0);
    check({tag, ".resp_ld"}, mem_ld, 1'b0);
    if (port == PORT_IF) p0_req = 1'b0; else p1_req = 1'b0;
    $display("access %s port=%0d we=%0d sel=%h addr=%0d wdata=%h rdata_exp=%h",
             tag, port, we, sel, addr, wdata, exp_rdata);
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_sel = '0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_sel = '0; p1_addr = '0; p1_wdata = '0;

    // Reset state
    #3;
    check("rst.p0_ack", p0_ack, 1'b0);
    check("rst.p1_ack", p1_ack, 1'b0);
    check("rst.clr_done", clr_done, 1'b0);
    check("rst.mem_str", mem_str, 1'b0);
    check("rst.mem_ld", mem_ld, 1'b0);
    check("rst.mem_clr", mem_clr, 1'b0);
    check("rst.mem_sel", mem_sel, 4'h0);
    check("rst.mem_addr", mem_addr, 4'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // p1 full write, then p0 reads it back
    access(PORT_LS, 1'b1, SEL_ALL, 4'd3, 32'hA5A5_1234, 32'h0, "s1_wr");
    access(PORT_IF, 1'b0, SEL_ALL, 4'd3, 32'h0, 32'hA5A5_1234, "s1_rd");
    tick();

    // Byte-lane writes and masked reads
    access(PORT_LS, 1'b1, SEL_ALL, 4'd3, 32'h1111_1111, 32'h0, "s2_fill");
    access(PORT_LS, 1'b1, 4'b0100, 4'd3, 32'h00FF_0000, 32'h0, "s2_lane2");
    access(PORT_LS, 1'b0, SEL_ALL, 4'd3, 32'h0, 32'h11FF_1111, "s2_rd");
    access(PORT_LS, 1'b1, 4'b0000, 4'd3, 32'hFFFF_FFFF, 32'h0, "s2_wr_sel0");
    access(PORT_LS, 1'b0, SEL_ALL, 4'd3, 32'h0, 32'h11FF_1111, "s2_rd_after_sel0");
    access(PORT_LS, 1'b0, 4'b0011, 4'd3, 32'h0, 32'h0000_1111, "s2_rd_lo");
    access(PORT_LS, 1'b0, 4'b0000, 4'd3, 32'h0, 32'h0, "s2_rd_sel0");
    tick();

    // Request dropped during ISSUE still completes with an ack
    drive(PORT_LS, 1'b1, SEL_ALL, 4'd7, 32'h1234_5678);
    tick();
    check("drop.issue_str", mem_str, 1'b1);
    p1_req = 1'b0;
    tick();
    check("drop.ack", p1_ack, 1'b1);
    tick();
    check("drop.no_second_ack", p1_ack, 1'b0);
    $display("access drop_in_issue port=1 ack_seen");

    // Both ports held: alternate in RR, p0 only in fixed priority
    drive(PORT_IF, 1'b0, SEL_ALL, 4'd3, 32'h0);
    drive(PORT_LS, 1'b0, SEL_ALL, 4'd3, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      logic e0, e1;
      tick();
      e0 = (c % 2 == 0) && (!RR || (c % 4 == 2));
      e1 = (c % 2 == 0) && RR && (c % 4 == 0);
      check($sformatf("tie.c%0d.p0_ack", c), p0_ack, e0);
      check($sformatf("tie.c%0d.p1_ack", c), p1_ack, e1);
      if (e0) check($sformatf("tie.c%0d.p0_rdata", c), p0_rdata, 32'h11FF_1111);
      if (e1) check($sformatf("tie.c%0d.p1_rdata", c), p1_rdata, 32'h11FF_1111);
      $display("tie cycle=%0d p0_ack=%0d p1_ack=%0d", c, p0_ack, p1_ack);
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick();

    // Clear beats a simultaneous p1 read; the read then sees zero
    drive(PORT_LS, 1'b0, SEL_ALL, 4'd3, 32'h0);
    clr_req = 1'b1;
    tick();
    check("clr.mem_clr", mem_clr, 1'b1);
    check("clr.mem_ld", mem_ld, 1'b0);
    check("clr.mem_str", mem_str, 1'b0);
    check("clr.mem_addr", mem_addr, 4'h0);
    check("clr.done_early", clr_done, 1'b0);
    tick();
    check("clr.done", clr_done, 1'b1);
    check("clr.mem_clr_off", mem_clr, 1'b0);
    check("clr.p1_noack", p1_ack, 1'b0);
    clr_req = 1'b0;
    tick();
    check("clr.p1_issue_ld", mem_ld, 1'b1);
    check("clr.done_pulse", clr_done, 1'b0);
    tick();
    check("clr.p1_ack", p1_ack, 1'b1);
    check("clr.p1_rdata", p1_rdata, 32'h0);
    p1_req = 1'b0;
    $display("access clear_then_p1_read rdata=%h", p1_rdata);
    tick();

    // Reset during ISSUE drops the access; a re-issued read works
    access(PORT_IF, 1'b1, SEL_ALL, 4'd5, 32'hDEAD_BEEF, 32'h0, "s5_wr");
    tick();
    drive(PORT_IF, 1'b0, SEL_ALL, 4'd5, 32'h0);
    tick();
    check("rstmid.issue_ld", mem_ld, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.mem_ld", mem_ld, 1'b0);
    check("rstmid.mem_addr", mem_addr, 4'h0);
    check("rstmid.mem_sel", mem_sel, 4'h0);
    check("rstmid.p0_ack", p0_ack, 1'b0);
    p0_req = 1'b0;
    tick();
    check("rstmid.no_ack", p0_ack, 1'b0);
    check("rstmid.p0_rdata", p0_rdata, 32'h0);
    rst_n = 1'b1;
    tick();
    access(PORT_IF, 1'b0, SEL_ALL, 4'd5, 32'h0, 32'hDEAD_BEEF, "s5_reread");
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
